// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: captures strobed L/R samples and serializes them onto a 3-wire I2S link (256-clk frame).
// Latency: a sample held before cnt==ff goes out in the next frame; every output lags cnt by 1 clk.
// Backpressure: none; a channel without a fresh strobe repeats its last value and UNDERRUN_OUT pulses.
// Optional: define LJ_FORMAT_EN for left-justified framing (MSB in slot 0) instead of I2S.
module audio_i2s_tx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_LEFT_IN,
  input  logic              SAMPLING_POINT_LEFT_IN,
  input  logic [DATA_W-1:0] DATA_RIGHT_IN,
  input  logic              SAMPLING_POINT_RIGHT_IN,
  output logic              BCLK_OUT,
  output logic              LRCK_OUT,
  output logic              SDATA_OUT,
  output logic              FRAME_SYNC_OUT,
  output logic              UNDERRUN_OUT
);

  logic [7:0]        cnt;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] frame_l;
  logic [DATA_W-1:0] frame_r;
  logic              new_l;
  logic              new_r;
  logic              load;
  logic [4:0]        slot;
  logic [5:0]        slot_w;
  logic [5:0]        bit_idx;
  logic              slot_act;
  logic [DATA_W-1:0] word;
  logic              sdata_nxt;

  assign load   = (cnt == 8'hff);
  assign slot   = cnt[6:2];
  assign slot_w = {1'b0, slot};
  assign word   = cnt[7] ? frame_r : frame_l;

`ifdef LJ_FORMAT_EN
  // MSB sits in slot 0, aligned with the LRCK edge
  assign slot_act = (slot_w < 6'(DATA_W));
  assign bit_idx  = 6'(DATA_W - 1) - slot_w;
`else
  // I2S: slot 0 is the one-BCLK gap after the LRCK edge, MSB in slot 1
  assign slot_act = (slot != 5'd0) && (slot_w <= 6'(DATA_W));
  assign bit_idx  = 6'(DATA_W) - slot_w;
`endif

  // Free-running frame position counter, wraps every 256 clk
  always_ff @(posedge clk) begin
    if (RESET) cnt <= 8'd0;
    else       cnt <= cnt + 8'd1;
  end

  // Hold stage: last strobe wins; freshness flags clear at load unless a strobe coincides
  always_ff @(posedge clk) begin
    if (RESET) begin
      hold_l <= '0;
      hold_r <= '0;
      new_l  <= 1'b0;
      new_r  <= 1'b0;
    end else begin
      if (SAMPLING_POINT_LEFT_IN)  hold_l <= DATA_LEFT_IN;
      if (SAMPLING_POINT_RIGHT_IN) hold_r <= DATA_RIGHT_IN;
      new_l <= SAMPLING_POINT_LEFT_IN  | (new_l & ~load);
      new_r <= SAMPLING_POINT_RIGHT_IN | (new_r & ~load);
    end
  end

  // Frame load: take the hold values (old ones if a strobe lands on the same edge)
  always_ff @(posedge clk) begin
    if (RESET) begin
      frame_l <= '0;
      frame_r <= '0;
    end else if (load) begin
      frame_l <= hold_l;
      frame_r <= hold_r;
    end
  end

  // Pick the bit of the active channel word for the current slot; idle slots carry 0
  always_comb begin
    sdata_nxt = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (slot_act && (bit_idx == 6'(i))) sdata_nxt = word[i];
    end
  end

  // Registered link outputs; SDATA only moves when BCLK falls since both derive from cnt
  always_ff @(posedge clk) begin
    if (RESET) begin
      BCLK_OUT       <= 1'b0;
      LRCK_OUT       <= 1'b0;
      SDATA_OUT      <= 1'b0;
      FRAME_SYNC_OUT <= 1'b0;
      UNDERRUN_OUT   <= 1'b0;
    end else begin
      BCLK_OUT       <= cnt[1];
      LRCK_OUT       <= cnt[7];
      SDATA_OUT      <= sdata_nxt;
      FRAME_SYNC_OUT <= load;
      UNDERRUN_OUT   <= load & ~(new_l & new_r);
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: table-driven frame stimulus with a scoreboard of expected words per half-frame.
// A BCLK-rising-edge deserializer recovers each channel word; load pulses are checked per frame.
// Waveform rules (BCLK/LRCK phase, SDATA moving only on BCLK fall) are tracked continuously.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              RESET;
  logic [DATA_W-1:0] DATA_LEFT_IN;
  logic              SAMPLING_POINT_LEFT_IN;
  logic [DATA_W-1:0] DATA_RIGHT_IN;
  logic              SAMPLING_POINT_RIGHT_IN;
  logic              BCLK_OUT;
  logic              LRCK_OUT;
  logic              SDATA_OUT;
  logic              FRAME_SYNC_OUT;
  logic              UNDERRUN_OUT;

  always #5 clk = ~clk;

  audio_i2s_tx #(.DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .RESET                   (RESET),
    .DATA_LEFT_IN            (DATA_LEFT_IN),
    .SAMPLING_POINT_LEFT_IN  (SAMPLING_POINT_LEFT_IN),
    .DATA_RIGHT_IN           (DATA_RIGHT_IN),
    .SAMPLING_POINT_RIGHT_IN (SAMPLING_POINT_RIGHT_IN),
    .BCLK_OUT                (BCLK_OUT),
    .LRCK_OUT                (LRCK_OUT),
    .SDATA_OUT               (SDATA_OUT),
    .FRAME_SYNC_OUT          (FRAME_SYNC_OUT),
    .UNDERRUN_OUT            (UNDERRUN_OUT)
  );

  typedef struct {
    logic [DATA_W-1:0] w;
    logic              ch;
  } half_t;

  typedef struct {
    logic              rst;
    logic              sl;
    logic [DATA_W-1:0] dl;
    logic [7:0]        al;
    logic              sl2;
    logic [DATA_W-1:0] dl2;
    logic [7:0]        al2;
    logic              sr;
    logic [DATA_W-1:0] dr;
    logic [7:0]        ar;
    logic [DATA_W-1:0] el;
    logic [DATA_W-1:0] er;
    logic              eu;
  } row_t;

  half_t dq[$];
  logic  uq[$];
  int    errors = 0;
  int    checks = 0;
  int    stray  = 0;
  int    wave_err = 0;
  logic  active = 1'b1;
  logic [7:0] tcnt;
  row_t  rows[12];

  // Reference frame position, derived from reset release only
  always @(posedge clk) begin
    if (RESET) tcnt <= 8'd0;
    else       tcnt <= tcnt + 8'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input logic rst,
                              input logic sl, input logic [DATA_W-1:0] dl, input logic [7:0] al,
                              input logic sl2, input logic [DATA_W-1:0] dl2, input logic [7:0] al2,
                              input logic sr, input logic [DATA_W-1:0] dr, input logic [7:0] ar,
                              input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er,
                              input logic eu);
    row_t r;
    r.rst = rst; r.sl = sl; r.dl = dl; r.al = al; r.sl2 = sl2; r.dl2 = dl2; r.al2 = al2;
    r.sr = sr; r.dr = dr; r.ar = ar; r.el = el; r.er = er; r.eu = eu;
    return r;
  endfunction

  // Deserializer, load-pulse and waveform monitors, sampled mid-cycle
  initial begin : monitors
    logic [31:0] bits;
    logic [31:0] tmp;
    int          bitn;
    logic        ch0;
    logic        lrck_bad;
    logic        prev_bclk;
    logic        prev_sdata;
    logic        rst_prev;
    logic [7:0]  last_tc;
    logic [DATA_W-1:0] w;
    logic        pad;
    logic        b;
    half_t       e;
    bits = '0; bitn = 0; ch0 = 1'b0; lrck_bad = 1'b0;
    prev_bclk = 1'b0; prev_sdata = 1'b0; rst_prev = 1'b1; last_tc = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_prev && BCLK_OUT && !prev_bclk) begin
        bits = {SDATA_OUT, bits[31:1]};
        if (bitn == 0) ch0 = LRCK_OUT;
        else if (LRCK_OUT != ch0) lrck_bad = 1'b1;
        bitn++;
        if (bitn == 32) begin
          tmp = bits; w = '0; pad = 1'b0;
          for (int s = 0; s < 32; s++) begin
            b = tmp[0];
            tmp = tmp >> 1;
`ifdef LJ_FORMAT_EN
            if (s < DATA_W) w = {w[DATA_W-2:0], b};
            else            pad = pad | b;
`else
            if (s >= 1 && s <= DATA_W) w = {w[DATA_W-2:0], b};
            else                       pad = pad | b;
`endif
          end
          if (dq.size() == 0) begin
            check("half_unexpected", 64'({ch0, w}), 64'(0));
          end else begin
            e = dq.pop_front();
            check(e.ch ? "word_right" : "word_left", 64'({ch0, w}), 64'({e.ch, e.w}));
            check("pad_slots_lrck_steady", 64'({pad, lrck_bad}), 64'(0));
          end
          bitn = 0; lrck_bad = 1'b0;
        end
      end
      if (RESET) begin
        bitn = 0; lrck_bad = 1'b0;
      end
      if (active && !rst_prev) begin
        if (BCLK_OUT != last_tc[1] || LRCK_OUT != last_tc[7]) wave_err++;
        if (SDATA_OUT != prev_sdata && !(prev_bclk && !BCLK_OUT)) wave_err++;
        if (last_tc == 8'hff) begin
          if (uq.size() == 0) check("load_unexpected", 64'(UNDERRUN_OUT), 64'(0));
          else check("sync_underrun", 64'({FRAME_SYNC_OUT, UNDERRUN_OUT}), 64'({1'b1, uq.pop_front()}));
        end else if (FRAME_SYNC_OUT || UNDERRUN_OUT) begin
          stray++;
        end
      end
      prev_bclk = BCLK_OUT; prev_sdata = SDATA_OUT; rst_prev = RESET; last_tc = tcnt;
    end
  end

  task automatic idle_inputs();
    SAMPLING_POINT_LEFT_IN  = 1'b0;
    SAMPLING_POINT_RIGHT_IN = 1'b0;
    DATA_LEFT_IN  = DATA_W'($urandom);
    DATA_RIGHT_IN = DATA_W'($urandom);
  endtask

  // One frame of strobes; expected content of the next frame is queued up front
  task automatic run_row(input row_t r);
    dq.push_back('{w: r.el, ch: 1'b0});
    dq.push_back('{w: r.er, ch: 1'b1});
    uq.push_back(r.eu);
    for (int c = 0; c < 256; c++) begin
      idle_inputs();
      if (r.sl  && tcnt == r.al)  begin SAMPLING_POINT_LEFT_IN = 1'b1;  DATA_LEFT_IN = r.dl;  end
      if (r.sl2 && tcnt == r.al2) begin SAMPLING_POINT_LEFT_IN = 1'b1;  DATA_LEFT_IN = r.dl2; end
      if (r.sr  && tcnt == r.ar)  begin SAMPLING_POINT_RIGHT_IN = 1'b1; DATA_RIGHT_IN = r.dr; end
      @(posedge clk); #2;
    end
    idle_inputs();
  endtask

  // One-clk reset at cnt=0x40 with strobes on the same cycle that must be ignored
  task automatic reset_mid_frame();
    for (int c = 0; c < 8'h40; c++) begin
      idle_inputs();
      @(posedge clk); #2;
    end
    check("pre_reset_cnt", 64'(tcnt), 64'(8'h40));
    RESET = 1'b1;
    SAMPLING_POINT_LEFT_IN  = 1'b1; DATA_LEFT_IN  = 24'h5A5A5A;
    SAMPLING_POINT_RIGHT_IN = 1'b1; DATA_RIGHT_IN = 24'hA5A5A5;
    @(posedge clk); #2;
    check("mid_reset_outputs_zero",
          64'({BCLK_OUT, LRCK_OUT, SDATA_OUT, FRAME_SYNC_OUT, UNDERRUN_OUT}), 64'(0));
    RESET = 1'b0;
    idle_inputs();
    dq.delete();
    dq.push_back('{w: '0, ch: 1'b0});
    dq.push_back('{w: '0, ch: 1'b1});
  endtask

  initial begin : stimulus
    int n;
    rows[0]  = mk(0, 1, 24'h800001, 8'h10, 0, '0, 8'h00, 1, 24'h7FFFFE, 8'h10, 24'h800001, 24'h7FFFFE, 0);
    rows[1]  = mk(0, 0, '0, 8'h00, 0, '0, 8'h00, 0, '0, 8'h00, 24'h800001, 24'h7FFFFE, 1);
    rows[2]  = mk(0, 0, '0, 8'h00, 0, '0, 8'h00, 0, '0, 8'h00, 24'h800001, 24'h7FFFFE, 1);
    rows[3]  = mk(0, 0, '0, 8'h00, 0, '0, 8'h00, 0, '0, 8'h00, 24'h800001, 24'h7FFFFE, 1);
    rows[4]  = mk(0, 1, 24'h123456, 8'h20, 0, '0, 8'h00, 0, '0, 8'h00, 24'h123456, 24'h7FFFFE, 1);
    rows[5]  = mk(0, 1, 24'hABCDEF, 8'hFF, 0, '0, 8'h00, 1, 24'h111111, 8'h10, 24'h123456, 24'h111111, 1);
    rows[6]  = mk(0, 0, '0, 8'h00, 0, '0, 8'h00, 1, 24'h222222, 8'h30, 24'hABCDEF, 24'h222222, 0);
    rows[7]  = mk(0, 1, 24'h000001, 8'h40, 1, 24'h654321, 8'h80, 1, 24'h000000, 8'h50, 24'h654321, 24'h000000, 0);
    rows[8]  = mk(0, 1, 24'h800000, 8'h7F, 0, '0, 8'h00, 1, 24'hFFFFFF, 8'h00, 24'h800000, 24'hFFFFFF, 0);
    rows[9]  = mk(1, 0, '0, 8'h00, 0, '0, 8'h00, 0, '0, 8'h00, '0, '0, 0);
    rows[10] = mk(0, 0, '0, 8'h00, 0, '0, 8'h00, 0, '0, 8'h00, 24'h000000, 24'h000000, 1);
    rows[11] = mk(0, 1, 24'h0F0F0F, 8'h10, 0, '0, 8'h00, 1, 24'hF0F0F0, 8'h10, 24'h0F0F0F, 24'hF0F0F0, 0);

    RESET = 1'b1;
    idle_inputs();
    SAMPLING_POINT_LEFT_IN = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_zero",
          64'({BCLK_OUT, LRCK_OUT, SDATA_OUT, FRAME_SYNC_OUT, UNDERRUN_OUT}), 64'(0));
    idle_inputs();
    dq.push_back('{w: '0, ch: 1'b0});
    dq.push_back('{w: '0, ch: 1'b1});
    RESET = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (rows[i].rst) reset_mid_frame();
      else             run_row(rows[i]);
    end

    n = 0;
    while (dq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    active = 1'b0;
    check("scoreboard_drained", 64'(dq.size()), 64'(0));
    check("load_queue_drained", 64'(uq.size()), 64'(0));
    check("stray_pulses", 64'(stray), 64'(0));
    check("waveform_violations", 64'(wave_err), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Transmit end of the parallel audio sample interface (data word plus one-clk SAMPLING_POINT strobe per channel).
- Captures left/right samples from the upstream processing block and serializes them onto a 3-wire I2S link (BCLK, LRCK, SDATA) toward the DAC.
- Frame is fixed at 256 clk: 128 clk per channel, 32 BCLK slots per channel; 12.288 MHz clk gives a 48 kHz frame.
- Flags frames that carry no fresh sample.

Parameters:
- DATA_W, 24, sample width in bits. Legal range: 1..31 in I2S mode, 1..32 with LJ_FORMAT_EN.

Ports:
- clk  input  1  system clock (12.288 MHz)
- RESET  input  1  synchronous, active-high reset
- DATA_LEFT_IN  input  DATA_W  left sample, two's complement
- SAMPLING_POINT_LEFT_IN  input  1  one-clk strobe; DATA_LEFT_IN valid
- DATA_RIGHT_IN  input  DATA_W  right sample
- SAMPLING_POINT_RIGHT_IN  input  1  one-clk strobe; DATA_RIGHT_IN valid
- BCLK_OUT  output  1  bit clock, clk/4
- LRCK_OUT  output  1  word select; 0 = left, 1 = right
- SDATA_OUT  output  1  serial data, MSB first
- FRAME_SYNC_OUT  output  1  one-clk pulse at each frame load
- UNDERRUN_OUT  output  1  one-clk pulse when a loaded frame lacks a fresh sample on either channel

Behaviour:
- cnt[7:0] is a free-running counter. It resets to 0 and increments by 1 each clk, wrapping ff→00.
- Derived fields: ch = cnt[7]; slot = cnt[6:2] (0..31); bclk phase = cnt[1].
- Hold stage:
  - SAMPLING_POINT_LEFT_IN=1 → hold_L <= DATA_LEFT_IN and new_L <= 1. Right channel works the same way (hold_R, new_R).
  - A strobe with no intervening load overwrites the held value; last one wins.
- Frame load on cnt==ff:
  - frame_L <= hold_L and frame_R <= hold_R.
  - Next cycle, FRAME_SYNC_OUT=1.
  - Next cycle, UNDERRUN_OUT = ~(new_L & new_R).
  - new_L and new_R are cleared.
  - On underrun, the stale channel retransmits its previous hold value.
- Strobe coincident with load: the load takes the old hold value. hold and new_x then update, so the new sample goes out in the following frame and counts as fresh for that frame's load.
- Serial mapping, I2S default. For word w = ch ? frame_R : frame_L:
  - slot s in 1..DATA_W → bit w[DATA_W-s];
  - all other slots → 0.
  - This gives the standard one-BCLK delay after the LRCK edge.
- Output registers: all outputs are registered from the current cnt, so they lag cnt by exactly 1 clk.
  - BCLK_OUT <= cnt[1]
  - LRCK_OUT <= cnt[7]
  - SDATA_OUT <= mapped bit
  - SDATA therefore changes only on BCLK falling edges and is stable across rising edges.
- Latency: a sample strobed before cnt==ff has its MSB on SDATA_OUT during the clk cycles where cnt = 05..08 (I2S) of the following left/right half.
- Reset values, all 0: cnt, hold_L/R, new_L/R, frame_L/R, BCLK_OUT, LRCK_OUT, SDATA_OUT, FRAME_SYNC_OUT, UNDERRUN_OUT.
- RESET mid-frame: all state clears on that edge; outputs read 0 on the following cycle and the frame restarts at cnt=0.
- The first load after reset with no strobes yields UNDERRUN_OUT=1 and all-zero data.
- Strobes during RESET are ignored.

Optional Feature:
- Macro: LJ_FORMAT_EN.
- Defined: left-justified format. Slot s in 0..DATA_W-1 → w[DATA_W-1-s]; remaining slots 0. The MSB aligns with the LRCK edge; LRCK polarity is unchanged.
- Undefined: I2S mapping as above.

Test Plan:
- Reset, then strobe L=0x800001 and R=0x7FFFFE at cnt=0x10 → load at ff gives FRAME_SYNC_OUT=1 and UNDERRUN_OUT=0. Bench deserializer on BCLK rising edges recovers L=0x800001 and R=0x7FFFFE, with slot 0 and slots 25..31 = 0.
- No strobes for 3 frames after a valid frame → UNDERRUN_OUT pulses at each of the 3 loads; SDATA repeats 0x800001/0x7FFFFE.
- Strobe L=0x123456 only, with no right strobe → UNDERRUN_OUT=1; left carries 0x123456 and right repeats its previous value.
- Strobe L=0xABCDEF coincident with cnt==ff → current frame sends the old left value; next frame sends 0xABCDEF with UNDERRUN_OUT=0, provided the right channel was also strobed.
- Waveform check → BCLK_OUT period 4 clk; LRCK_OUT toggles every 128 clk, low for left; SDATA_OUT changes only when BCLK_OUT falls.
- RESET asserted for 1 clk at cnt=0x40 → the next cycle shows all outputs 0; the first subsequent load has UNDERRUN_OUT=1 and zero data. A build with LJ_FORMAT_EN puts the MSB in slot 0.
